// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one full-subtractor cell plus a borrow flip-flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             dout_bit,
    output logic             dout_valid
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_br;
    logic [WIDTH-1:0] w_res;
    assign w_d   = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res = {w_d, r_res};
    assign busy  = r_state != IDLE;
    // DONE accepts a new start like IDLE, giving a WIDTH+1 cycle back-to-back period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            dout_bit   <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            done       <= 1'b0;
            dout_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a        <= r_a >> 1;
                    r_b        <= r_b >> 1;
                    r_res      <= w_res[WIDTH-1:1];
                    r_br       <= w_br;
                    r_cnt      <= r_cnt + CW'(1);
                    dout_bit   <= w_d;
                    dout_valid <= 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        diff       <= w_res;
                        borrow_out <= w_br;
                        done       <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: timeline model of the serial subtractor checked every cycle, plus directed literal cases and a 4-bit exhaustive sweep.
module tb_serial_subtractor;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out, dout_bit, dout_valid;
    logic [W-1:0] diff;
    logic         start4 = 1'b0;
    logic [3:0]   a4 = '0;
    logic [3:0]   b4 = '0;
    logic         busy4, done4, bor4, bit4, dv4;
    logic [3:0]   diff4;
    int           n_cmp = 0;
    int           n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
        .dout_bit(dout_bit), .dout_valid(dout_valid)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bor4),
        .dout_bit(bit4), .dout_valid(dv4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ph is cycles since the accepting edge (-1 = idle); the whole result is computed arithmetically at accept.
    int           ph = -1;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_diff = '0;
    logic         m_lt = 1'b0;
    logic         m_bor = 1'b0;
    logic         m_bit = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = -1;
            m_diff = '0;
            m_bor = 1'b0;
            m_bit = 1'b0;
        end else if (ph == -1 || ph == W) begin
            if (start) begin
                ph = 0;
                m_res = a - b;
                m_lt = a < b;
            end else begin
                ph = -1;
            end
        end else begin
            ph++;
            m_bit = m_res[ph-1];
            if (ph == W) begin
                m_diff = m_res;
                m_bor = m_lt;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(ph != -1));
        chk("done", 32'(done), 32'(ph == W));
        chk("dout_valid", 32'(dout_valid), 32'(ph >= 1));
        chk("dout_bit", 32'(dout_bit), 32'(m_bit));
        chk("diff", 32'(diff), 32'(m_diff));
        chk("borrow_out", 32'(borrow_out), 32'(m_bor));
    end

    logic [W-1:0] ser8 = '0;
    logic [3:0]   ser4 = '0;
    int           dv4n = 0;
    always @(negedge clk) begin
        if (dout_valid) ser8 = {dout_bit, ser8[W-1:1]};
        if (dv4) begin
            dv4n++;
            ser4 = {bit4, ser4[3:1]};
        end
    end

    task automatic wait_done8();
        logic got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done8_timeout", 32'(got), 32'd1);
    endtask

    task automatic run8(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ed, input logic eb);
        ser8 = '0;
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        wait_done8();
        @(negedge clk);
        chk("lit_diff", 32'(diff), 32'(ed));
        chk("lit_borrow", 32'(borrow_out), 32'(eb));
        chk("lit_serial", 32'(ser8), 32'(ed));
    endtask

    initial begin
        int n;
        logic got;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        // directed single operations
        run8(8'h5A, 8'h23, 8'h37, 1'b0);
        run8(8'h00, 8'h01, 8'hFF, 1'b1);
        run8(8'hAA, 8'hAA, 8'h00, 1'b0);
        run8(8'hFF, 8'h00, 8'hFF, 1'b0);
        // start held high: one done every W+1 cycles; a change mid-SHIFT only affects the next accept
        @(posedge clk);
        #2 a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        n = 0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (done) n++;
            if (i == 12) a = 8'h20;
            if (i == 18) chk("held_diff2", 32'(diff), 32'h0F);
            if (i == 27) chk("held_diff3", 32'(diff), 32'h1F);
        end
        start = 1'b0;
        chk("held_done_count", 32'(n), 32'd3);
        repeat (3) @(negedge clk);
        // start while busy is ignored
        a = 8'h40;
        b = 8'h04;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 a = 8'h01;
        b = 8'h02;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("ignored_done_count", 32'(n), 32'd1);
        chk("ignored_diff", 32'(diff), 32'h3C);
        chk("ignored_borrow", 32'(borrow_out), 32'd0);
        // asynchronous reset mid-operation
        a = 8'h5A;
        b = 8'h23;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_bit", 32'(dout_bit), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_borrow", 32'(borrow_out), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        run8(8'h03, 8'h05, 8'hFE, 1'b1);
        // randomized traffic checked by the model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2 start = ($urandom % 4) == 0;
            a = W'($urandom);
            b = W'($urandom);
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        // exhaustive 4-bit sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                #2 dv4n = 0;
                ser4 = '0;
                a4 = 4'(x);
                b4 = 4'(y);
                start4 = 1'b1;
                @(posedge clk);
                #2 start4 = 1'b0;
                got = 1'b0;
                for (int k = 0; k < 20 && !got; k++) begin
                    @(negedge clk);
                    if (done4) got = 1'b1;
                end
                chk("w4_done_timeout", 32'(got), 32'd1);
                @(negedge clk);
                chk("w4_diff", 32'(diff4), 32'((x - y) & 15));
                chk("w4_borrow", 32'(bor4), 32'(x < y));
                chk("w4_serial", 32'(ser4), 32'((x - y) & 15));
                chk("w4_valid_count", 32'(dv4n), 32'd4);
                chk("w4_busy_after", 32'(busy4), 32'd0);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
